multicycle_controller: RTL

Main control FSM for the multi-cycle RV32I datapath. The core shares one memory port, one ALU and the ALUOut/IR/oldPC registers across FETCH, DECODE, EXECUTE, MEM and WRITEBACK steps. This block drives every mux select and write strobe of that datapath. It handles memory wait-states through a mem_ready handshake with a bounded timeout.

---
 rtl/multicycle_controller.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with bounded memory wait-states
// Optional build macro MC_ILLEGAL_TRAP_EN: unrecognised opcodes park the core in TRAP.
module multicycle_controller #(
   parameter int MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic [3:0] state,
   output logic       instr_retired,
   output logic       mem_timeout,
   output logic       illegal_instr
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_EXEC_R  = 4'd6,
      S_ALU_WB  = 4'd7,
      S_EXEC_I  = 4'd8,
      S_JAL     = 4'd9,
      S_BRANCH  = 4'd10,
      S_TRAP    = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [7:0] WAIT_LIM  = 8'(MAX_WAIT);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_wait;
   logic       w_wait_state;
   logic       w_timeout;
   logic       w_taken;

   logic       w_pc_write, w_ir_write, w_adr_src, w_mem_read, w_mem_write, w_reg_write;
   logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;
   logic       w_retired, w_illegal;

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   assign w_timeout    = w_wait_state && !mem_ready && (r_wait == WAIT_LIM);
   assign w_taken      = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:   if (mem_ready) w_next = S_DECODE;
                    else if (w_timeout) w_next = S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
               OP_RTYPE:          w_next = S_EXEC_R;
               OP_ITYPE:          w_next = S_EXEC_I;
               OP_JAL:            w_next = S_JAL;
               OP_BRANCH:         w_next = S_BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
               default:           w_next = S_TRAP;
`else
               default:           w_next = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADR: w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:  if (mem_ready) w_next = S_MEM_WB;
                    else if (w_timeout) w_next = S_FETCH;
         S_MEM_WB:  w_next = S_FETCH;
         S_MEM_WR:  if (mem_ready || w_timeout) w_next = S_FETCH;
         S_EXEC_R:  w_next = S_ALU_WB;
         S_EXEC_I:  w_next = S_ALU_WB;
         S_ALU_WB:  w_next = S_FETCH;
         S_JAL:     w_next = S_ALU_WB;
         S_BRANCH:  w_next = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP:    w_next = S_TRAP;
`else
         S_TRAP:    w_next = S_FETCH;
`endif
         default:   w_next = S_FETCH;
      endcase
   end

   // Counter only runs while parked in a memory state; any exit or completion restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_wait  <= 8'd0;
      end else begin
         r_state <= w_next;
         if (!w_wait_state || mem_ready || w_timeout || (w_next != r_state))
            r_wait <= 8'd0;
         else
            r_wait <= r_wait + 8'd1;
      end
   end

   always_comb begin
      w_pc_write   = 1'b0;
      w_ir_write   = 1'b0;
      w_adr_src    = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b00;
      w_alu_op     = 2'b00;
      w_result_src = 2'b00;
      w_retired    = 1'b0;
      w_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read   = 1'b1;
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
            w_ir_write   = mem_ready;
            w_pc_write   = mem_ready;
         end
         S_DECODE: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b01;
`ifndef MC_ILLEGAL_TRAP_EN
            case (opcode)
               OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: w_retired = 1'b0;
               default: w_retired = 1'b1;
            endcase
`endif
         end
         S_MEM_ADR: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
         end
         S_MEM_RD: begin
            w_adr_src  = 1'b1;
            w_mem_read = 1'b1;
         end
         S_MEM_WB: begin
            w_result_src = 2'b01;
            w_reg_write  = 1'b1;
            w_retired    = 1'b1;
         end
         S_MEM_WR: begin
            w_adr_src   = 1'b1;
            w_mem_write = !w_timeout;
            w_retired   = mem_ready;
         end
         S_EXEC_R: begin
            w_alu_src_a = 2'b10;
            w_alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
            w_alu_op    = 2'b10;
         end
         S_ALU_WB: begin
            w_reg_write = 1'b1;
            w_retired   = 1'b1;
         end
         S_JAL: begin
            w_pc_write  = 1'b1;
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b10;
         end
         S_BRANCH: begin
            w_alu_src_a = 2'b10;
            w_alu_op    = 2'b01;
            w_pc_write  = w_taken;
            w_retired   = 1'b1;
         end
         S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
            w_illegal = 1'b1;
`endif
         end
         default: w_illegal = 1'b0;
      endcase
   end

   // Gate with rst_n so no strobe survives the falling edge of reset, even mid-cycle.
   assign pc_write      = rst_n & w_pc_write;
   assign ir_write      = rst_n & w_ir_write;
   assign adr_src       = rst_n & w_adr_src;
   assign mem_read      = rst_n & w_mem_read;
   assign mem_write     = rst_n & w_mem_write;
   assign reg_write     = rst_n & w_reg_write;
   assign alu_src_a     = {2{rst_n}} & w_alu_src_a;
   assign alu_src_b     = {2{rst_n}} & w_alu_src_b;
   assign alu_op        = {2{rst_n}} & w_alu_op;
   assign result_src    = {2{rst_n}} & w_result_src;
   assign instr_retired = rst_n & w_retired;
   assign mem_timeout   = rst_n & w_timeout;
   assign illegal_instr = rst_n & w_illegal;
   assign state         = r_state;

endmodule
